branch_resolve_queue: RTL and testbench

- Writer-side companion of the branch target buffer.
- FIFO that captures the BTB prediction metadata for each branch when fetch sends it down the pipeline (PC, hit, way, predicted target).
- Pops the oldest entry when execute resolves that branch, then:
  - drives the BTB write port (taken, way, BIA, index, target);
  - raises a registered mispredict/redirect to fetch and flushes younger entries.

---
 rtl/branch_resolve_queue.sv | 133 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-flight branch metadata FIFO driving BTB updates and mispredict redirects
module branch_resolve_queue #(
  parameter int DEPTH       = 4,
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int BIA_WIDTH   = 60,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [ADDR_WIDTH-1:0]   i_push_pc,
  input  logic                    i_push_hit,
  input  logic [$clog2(N)-1:0]    i_push_way,
  input  logic [ADDR_WIDTH-1:0]   i_push_target,
  output logic                    o_full,
  output logic                    o_empty,
  input  logic                    i_resolve,
  input  logic                    i_resolve_taken,
  input  logic [ADDR_WIDTH-1:0]   i_resolve_target,
  output logic                    o_branch_taken,
  output logic [$clog2(N)-1:0]    o_way_write,
  output logic [BIA_WIDTH-1:0]    o_bia_write,
  output logic [INDEX_WIDTH-1:0]  o_index_write,
  output logic [ADDR_WIDTH-1:0]   o_target_addr,
  output logic                    o_mispredict,
  output logic [ADDR_WIDTH-1:0]   o_redirect_pc,
  output logic                    o_resolve_err
);

  localparam int WAY_W = $clog2(N);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
  logic                  hit_mem [DEPTH];
  logic [WAY_W-1:0]      way_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  head_hit;
  logic [WAY_W-1:0]      head_way;
  logic [ADDR_WIDTH-1:0] head_tgt;

  logic                  pop;
  logic                  mispredict;
  logic                  push_ok;
  logic                  resolve_err;
  logic [ADDR_WIDTH-1:0] redirect;

  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);

  assign head_pc  = pc_mem[rd_ptr];
  assign head_hit = hit_mem[rd_ptr];
  assign head_way = way_mem[rd_ptr];
  assign head_tgt = tgt_mem[rd_ptr];

  always_comb begin
    pop         = i_resolve & ~o_empty & ~i_flush;
    resolve_err = i_resolve & o_empty & ~i_flush;
    mispredict  = 1'b0;
    redirect    = '0;
    if (pop) begin
      if (i_resolve_taken && (!head_hit || head_tgt != i_resolve_target)) begin
        mispredict = 1'b1;
        redirect   = i_resolve_target;
      end else if (!i_resolve_taken && head_hit) begin
        mispredict = 1'b1;
        redirect   = head_pc + ADDR_WIDTH'(4);
      end
    end
    // A push in the same cycle as a mispredict is on the wrong path
    push_ok = i_push & ~o_full & ~i_flush & ~mispredict;
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_arst) begin
      pc_mem[wr_ptr]  <= i_push_pc;
      hit_mem[wr_ptr] <= i_push_hit;
      way_mem[wr_ptr] <= i_push_way;
      tgt_mem[wr_ptr] <= i_push_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_flush || mispredict) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      o_branch_taken <= 1'b0;
      o_way_write    <= '0;
      o_bia_write    <= '0;
      o_index_write  <= '0;
      o_target_addr  <= '0;
      o_mispredict   <= 1'b0;
      o_redirect_pc  <= '0;
      o_resolve_err  <= 1'b0;
    end else begin
      o_branch_taken <= pop & i_resolve_taken;
      o_way_write    <= pop ? head_way : '0;
      o_bia_write    <= pop ? head_pc[ADDR_WIDTH-1:INDEX_WIDTH+2] : '0;
      o_index_write  <= pop ? head_pc[INDEX_WIDTH+1:2] : '0;
      o_target_addr  <= pop ? i_resolve_target : '0;
      o_mispredict   <= mispredict;
      o_redirect_pc  <= redirect;
      o_resolve_err  <= resolve_err;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - table-driven bench for branch_resolve_queue
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        arst;
  logic        flush;
  logic        push;
  logic [63:0] push_pc;
  logic        push_hit;
  logic [1:0]  push_way;
  logic [63:0] push_target;
  logic        full;
  logic        empty;
  logic        resolve;
  logic        resolve_taken;
  logic [63:0] resolve_target;
  logic        branch_taken;
  logic [1:0]  way_write;
  logic [59:0] bia_write;
  logic [1:0]  index_write;
  logic [63:0] target_addr;
  logic        mispredict;
  logic [63:0] redirect_pc;
  logic        resolve_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .i_clk(clk), .i_arst(arst), .i_flush(flush),
    .i_push(push), .i_push_pc(push_pc), .i_push_hit(push_hit),
    .i_push_way(push_way), .i_push_target(push_target),
    .o_full(full), .o_empty(empty),
    .i_resolve(resolve), .i_resolve_taken(resolve_taken), .i_resolve_target(resolve_target),
    .o_branch_taken(branch_taken), .o_way_write(way_write), .o_bia_write(bia_write),
    .o_index_write(index_write), .o_target_addr(target_addr),
    .o_mispredict(mispredict), .o_redirect_pc(redirect_pc), .o_resolve_err(resolve_err)
  );

  typedef struct {
    logic        fl;
    logic        pu;
    logic [63:0] pc;
    logic        hit;
    logic [1:0]  way;
    logic [63:0] ptgt;
    logic        res;
    logic        tk;
    logic [63:0] rtgt;
    logic        e_full;
    logic        e_empty;
    logic        e_bt;
    logic [1:0]  e_way;
    logic [59:0] e_bia;
    logic [1:0]  e_idx;
    logic [63:0] e_tgt;
    logic        e_mis;
    logic [63:0] e_rpc;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, step, act, exp);
    end
  endtask

  // Drive on the falling edge, check 1ns after the following rising edge
  task automatic step(input vec_t v, input logic rst, input int id);
    @(negedge clk);
    arst           = rst;
    flush          = v.fl;
    push           = v.pu;
    push_pc        = v.pc;
    push_hit       = v.hit;
    push_way       = v.way;
    push_target    = v.ptgt;
    resolve        = v.res;
    resolve_taken  = v.tk;
    resolve_target = v.rtgt;
    @(posedge clk);
    #1;
    chk("full",     id, 64'(full),         64'(v.e_full));
    chk("empty",    id, 64'(empty),        64'(v.e_empty));
    chk("taken",    id, 64'(branch_taken), 64'(v.e_bt));
    chk("way",      id, 64'(way_write),    64'(v.e_way));
    chk("bia",      id, 64'(bia_write),    64'(v.e_bia));
    chk("index",    id, 64'(index_write),  64'(v.e_idx));
    chk("target",   id, target_addr,       v.e_tgt);
    chk("mispred",  id, 64'(mispredict),   64'(v.e_mis));
    chk("redirect", id, redirect_pc,       v.e_rpc);
    chk("err",      id, 64'(resolve_err),  64'(v.e_err));
  endtask

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  initial begin
    vec_t idle_empty;
    arst = 1'b1; flush = 1'b0; push = 1'b0; push_pc = '0; push_hit = 1'b0; push_way = '0;
    push_target = '0; resolve = 1'b0; resolve_taken = 1'b0; resolve_target = '0;

    idle_empty = '{O,O,64'h0,O,2'd0,64'h0,O,O,64'h0, O,I,O,2'd0,60'h0,2'd0,64'h0,O,64'h0,O};

    // fl pu pc hit way ptgt res tk rtgt | full empty bt way bia idx tgt mis rpc err
    add('{O,I,64'h1000,O,2'd2,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 0
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h2000, O,I,I,2'd2,60'h100,2'd0,64'h2000,I,64'h2000,O}); // 1 miss-taken
    add('{O,I,64'h1004,I,2'd1,64'h3000,O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 2
    add('{O,I,64'h1008,I,2'd3,64'h4000,O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 3
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h3000, O,O,I,2'd1,60'h100,2'd1,64'h3000,O,64'h0,   O}); // 4 correct hit
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,O,64'h0,    O,I,O,2'd3,60'h100,2'd2,64'h0,   I,64'h100C,O}); // 5 hit not taken
    add('{O,I,64'h1010,O,2'd0,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 6
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,O,64'h0,    O,I,O,2'd0,60'h101,2'd0,64'h0,   O,64'h0,   O}); // 7 ptrs now 1
    add('{O,I,64'h2000,O,2'd0,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 8
    add('{O,I,64'h2004,I,2'd1,64'h5000,O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 9
    add('{O,I,64'h2008,O,2'd2,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 10
    add('{O,I,64'h200C,I,2'd3,64'h6000,O,O,64'h0,    I,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 11 full
    add('{O,I,64'h3000,I,2'd0,64'h9999,O,O,64'h0,    I,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 12 dropped
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,O,64'h0,    O,O,O,2'd0,60'h200,2'd0,64'h0,   O,64'h0,   O}); // 13
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h5000, O,O,I,2'd1,60'h200,2'd1,64'h5000,O,64'h0,   O}); // 14
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,O,64'h0,    O,O,O,2'd2,60'h200,2'd2,64'h0,   O,64'h0,   O}); // 15
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h6000, O,I,I,2'd3,60'h200,2'd3,64'h6000,O,64'h0,   O}); // 16
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h7000, O,I,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   I}); // 17 empty resolve
    add(idle_empty);                                                                                  // 18
    add('{O,I,64'h4000,I,2'd1,64'h4100,O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 19
    add('{O,I,64'h4004,O,2'd0,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 20
    add('{O,I,64'h4008,O,2'd2,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 21
    add('{O,I,64'h5000,O,2'd1,64'h0,   I,I,64'h4200, O,I,I,2'd1,60'h400,2'd0,64'h4200,I,64'h4200,O}); // 22 wrong target + push
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h1234, O,I,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   I}); // 23 push was discarded
    add('{O,I,64'h6000,O,2'd1,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 24
    add('{O,I,64'h6004,I,2'd2,64'h7000,I,O,64'h0,    O,O,O,2'd1,60'h600,2'd0,64'h0,   O,64'h0,   O}); // 25 push+pop
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,I,64'h7000, O,I,I,2'd2,60'h600,2'd1,64'h7000,O,64'h0,   O}); // 26
    add('{O,I,64'h8000,O,2'd0,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 27
    add('{O,I,64'h8004,O,2'd1,64'h0,   O,O,64'h0,    O,O,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 28
    add('{I,I,64'h8008,O,2'd0,64'h0,   I,I,64'h9000, O,I,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   O}); // 29 flush
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,O,64'h0,    O,I,O,2'd0,60'h0,  2'd0,64'h0,   O,64'h0,   I}); // 30
    add('{O,I,64'hFFFF_FFFF_FFFF_FFFC,I,2'd0,64'h10,O,O,64'h0, O,O,O,2'd0,60'h0,2'd0,64'h0,O,64'h0,O}); // 31
    add('{O,O,64'h0,   O,2'd0,64'h0,   I,O,64'h0,    O,I,O,2'd0,60'hFFF_FFFF_FFFF_FFFF,2'd3,64'h0,I,64'h0,O}); // 32 pc+4 wraps

    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", -1, 64'(empty), 64'(1'b1));
    chk("rst_full",  -1, 64'(full),  64'(1'b0));
    chk("rst_taken", -1, 64'(branch_taken), 64'(1'b0));
    chk("rst_redir", -1, redirect_pc, 64'h0);
    chk("rst_err",   -1, 64'(resolve_err), 64'(1'b0));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k], 1'b0, k);

    // Reset mid-stream overrides a mispredicting resolve and a push
    step('{O,I,64'hA000,O,2'd1,64'h0,O,O,64'h0, O,O,O,2'd0,60'h0,2'd0,64'h0,O,64'h0,O}, 1'b0, 100);
    step('{O,I,64'hA004,O,2'd2,64'h0,O,O,64'h0, O,O,O,2'd0,60'h0,2'd0,64'h0,O,64'h0,O}, 1'b0, 101);
    step('{O,I,64'hA008,O,2'd3,64'h0,I,I,64'hB000, O,I,O,2'd0,60'h0,2'd0,64'h0,O,64'h0,O}, 1'b1, 102);
    step('{O,O,64'h0,O,2'd0,64'h0,I,I,64'hB000, O,I,O,2'd0,60'h0,2'd0,64'h0,O,64'h0,I}, 1'b0, 103);
    step(idle_empty, 1'b0, 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
